// File: rtl/wb_spi_controller.sv
// Wishbone-slave SPI master (mode 0, MSB first) for the management SoC command link.
// A TXDATA write runs one full-duplex frame. The received word lands in RXDATA.
module wb_spi_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DATA_BITS = 32,
    parameter logic [7:0]  DIV_RESET = 8'd3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_copi,
    input  logic        spi_cipo,
    output logic        irq
);
    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           div_lat_q, div_lat_d;
    logic [7:0]           ctrl_div_q, ctrl_div_d;
    logic                 irq_en_q, irq_en_d;
    logic [CW-1:0]        bits_q, bits_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0] tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_pend_q, rx_pend_d;
    logic [1:0]           smp_q, smp_d;
    logic                 sck_q, sck_d;
    logic                 cs_n_q, cs_n_d;
    logic                 copi_q, copi_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 ovr_q, ovr_d;
    logic                 ack_q, ack_d;
    logic [31:0]          dat_q, dat_d;
    logic                 irq_q, irq_d;
    logic                 cipo_s1_q, cipo_s2_q;

    logic       access, take, wr, rd, tx_wr, tx_accept, tc_zero, busy;
    logic [1:0] reg_sel;
    logic       rx_set;
    logic       unused_bits;

    assign access    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign take      = access & ~ack_q;
    assign wr        = take & wbs_we_i;
    assign rd        = take & ~wbs_we_i;
    assign reg_sel   = wbs_adr_i[3:2];
    assign tx_wr     = wr & (reg_sel == 2'd1);
    assign tc_zero   = (cnt_q == 8'd0);
    assign busy      = (state_q != S_IDLE);
    // The final GAP cycle already accepts a new frame so back-to-back writes are not lost.
    assign tx_accept = tx_wr & ((state_q == S_IDLE) | ((state_q == S_GAP) & tc_zero));
    assign unused_bits = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:9]};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign spi_sck   = sck_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_copi  = copi_q;
    assign irq       = irq_q;

    // Next-state, shift datapath and register file.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_lat_d  = div_lat_q;
        bits_d     = bits_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_pend_d  = rx_pend_q;
        smp_d      = {smp_q[0], 1'b0};
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        copi_d     = copi_q;
        ctrl_div_d = ctrl_div_q;
        irq_en_d   = irq_en_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        ack_d      = take;
        dat_d      = 32'd0;
        rx_set     = 1'b0;

        case (state_q)
            S_SETUP: begin
                if (tc_zero) begin
                    state_d  = S_SHIFT;
                    sck_d    = 1'b1;
                    cnt_d    = div_lat_q;
                    smp_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SHIFT: begin
                if (tc_zero) begin
                    cnt_d = div_lat_q;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bits_q == CW'(0)) begin
                            state_d = S_HOLD;
                        end else begin
                            tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
                            copi_d = tx_q[DATA_BITS-2];
                            bits_d = bits_q - CW'(1);
                        end
                    end else begin
                        sck_d    = 1'b1;
                        smp_d[0] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (tc_zero) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    cnt_d   = div_lat_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (tc_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Rising-edge strobe is delayed two cycles so it meets the pin value through the synchroniser.
        if (smp_q[1]) begin
            rx_sh_d  = {rx_sh_q[DATA_BITS-2:0], cipo_s2_q};
            rx_cnt_d = rx_cnt_q + CW'(1);
        end
        if (rx_pend_q && (rx_cnt_d == CW'(DATA_BITS)) &&
            ((state_q == S_HOLD) || (state_d == S_HOLD))) begin
            rx_data_d = rx_sh_d;
            rx_pend_d = 1'b0;
            rx_set    = 1'b1;
        end

        if (tx_accept) begin
            state_d   = S_SETUP;
            cs_n_d    = 1'b0;
            sck_d     = 1'b0;
            copi_d    = wbs_dat_i[DATA_BITS-1];
            tx_d      = wbs_dat_i[DATA_BITS-1:0];
            cnt_d     = ctrl_div_q;
            div_lat_d = ctrl_div_q;
            bits_d    = CW'(DATA_BITS - 1);
            rx_sh_d   = '0;
            rx_cnt_d  = '0;
            rx_pend_d = 1'b1;
        end else if (tx_wr) begin
            ovr_d = 1'b1;
        end

        if (wr && (reg_sel == 2'd0)) begin
            if (wbs_sel_i[0]) ctrl_div_d = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) irq_en_d   = wbs_dat_i[8];
        end
        if (wr && (reg_sel == 2'd3) && wbs_dat_i[2]) begin
            ovr_d = 1'b0;
        end

        if (rd && (reg_sel == 2'd2)) rx_valid_d = 1'b0;
        if (rx_set)                  rx_valid_d = 1'b1;

        if (rd) begin
            case (reg_sel)
                2'd0:    dat_d = {23'd0, irq_en_q, ctrl_div_q};
                2'd2:    dat_d = 32'(rx_data_q);
                2'd3:    dat_d = {29'd0, ovr_q, rx_valid_q, busy};
                default: dat_d = 32'd0;
            endcase
        end

        irq_d = rx_valid_d & irq_en_d;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            div_lat_q  <= 8'd0;
            ctrl_div_q <= DIV_RESET;
            irq_en_q   <= 1'b0;
            bits_q     <= '0;
            rx_cnt_q   <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_pend_q  <= 1'b0;
            smp_q      <= 2'b00;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            copi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            irq_q      <= 1'b0;
            cipo_s1_q  <= 1'b0;
            cipo_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_lat_q  <= div_lat_d;
            ctrl_div_q <= ctrl_div_d;
            irq_en_q   <= irq_en_d;
            bits_q     <= bits_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_pend_q  <= rx_pend_d;
            smp_q      <= smp_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            copi_q     <= copi_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
            cipo_s1_q  <= spi_cipo;
            cipo_s2_q  <= cipo_s1_q;
        end
    end
endmodule
